// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one read in flight and presents each
// fetched word downstream. Define IFU_MISALIGN_CHECK_EN to fault misaligned redirect targets.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_arvalid_o,
    input  logic            mem_arready_i,
    output logic [XLEN-1:0] mem_araddr_o,
    input  logic            mem_rvalid_i,
    output logic            mem_rready_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic [1:0]      mem_rresp_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_inst_o,
    output logic            out_fault_o
);

`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MisalignEn = 1'b1;
`else
    localparam bit MisalignEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q, req_addr_q, hold_pc_q, hold_inst_q;
    logic            drop_q, misal_q, hold_fault_q;

    logic [XLEN-1:0] redir_pc, seq_pc_d;
    logic            redir_misal, redir_now;

    assign redir_misal = MisalignEn && (redirect_pc_i[1:0] != 2'b00);
    assign redir_pc    = MisalignEn ? redirect_pc_i : {redirect_pc_i[XLEN-1:2], 2'b00};
    assign seq_pc_d    = hold_pc_q + XLEN'(4);

    // Redirect can restart immediately unless a transaction is still owed to the memory.
    assign redir_now = (state_q == StIdle) || (state_q == StHold) ||
                       ((state_q == StWait) && mem_rvalid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            drop_q       <= 1'b0;
            misal_q      <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= '0;
            hold_fault_q <= 1'b0;
        end else if (redirect_valid_i) begin
            pc_q    <= redir_pc;
            misal_q <= redir_misal;
            if (redir_now) begin
                drop_q <= 1'b0;
                if (redir_misal) begin
                    state_q      <= StHold;
                    hold_pc_q    <= redirect_pc_i;
                    hold_inst_q  <= '0;
                    hold_fault_q <= 1'b1;
                end else begin
                    state_q    <= StReq;
                    req_addr_q <= redir_pc;
                end
            end else begin
                // req_addr_q stays put so an un-accepted request is not altered.
                drop_q <= 1'b1;
                if (state_q == StReq && mem_arready_i) state_q <= StWait;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q    <= StReq;
                    req_addr_q <= pc_q;
                end
                StReq: begin
                    if (mem_arready_i) state_q <= StWait;
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        if (!drop_q) begin
                            state_q      <= StHold;
                            hold_pc_q    <= req_addr_q;
                            hold_inst_q  <= mem_rdata_i;
                            hold_fault_q <= (mem_rresp_i != 2'b00);
                        end else begin
                            drop_q  <= 1'b0;
                            misal_q <= 1'b0;
                            if (misal_q) begin
                                state_q      <= StHold;
                                hold_pc_q    <= pc_q;
                                hold_inst_q  <= '0;
                                hold_fault_q <= 1'b1;
                            end else begin
                                state_q    <= StReq;
                                req_addr_q <= pc_q;
                            end
                        end
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        pc_q       <= seq_pc_d;
                        req_addr_q <= seq_pc_d;
                        state_q    <= StReq;
                    end
                end
            endcase
        end
    end

    assign mem_arvalid_o = (state_q == StReq);
    assign mem_araddr_o  = req_addr_q;
    assign mem_rready_o  = (state_q == StWait);
    assign out_valid_o   = (state_q == StHold) && !redirect_valid_i;
    assign out_pc_o      = hold_pc_q;
    assign out_inst_o    = hold_inst_q;
    assign out_fault_o   = hold_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, then random traffic checked against a
// transaction-level PC model and an address-keyed memory image.
module tb_ifu_fetch;

    localparam logic [31:0] ResetPc = 32'h8000_0000;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_arvalid, mem_rready, out_valid, out_fault;
    logic        mem_arready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_araddr, out_pc, out_inst;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model and PC reference state
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_delay = 0;
    bit          rand_mem = 1'b0;
    int          ar_deny = 0;
    logic [31:0] exp_pc = ResetPc;
    bit          exp_mis = 1'b0;
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          ov_cnt = 0;
    int          hs_cnt = 0;
    int          since_hs = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(32), .RESET_PC(ResetPc)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .mem_arvalid_o   (mem_arvalid),
        .mem_arready_i   (mem_arready),
        .mem_araddr_o    (mem_araddr),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rready_o    (mem_rready),
        .mem_rdata_i     (mem_rdata),
        .mem_rresp_i     (mem_rresp),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_pc_o        (out_pc),
        .out_inst_o      (out_inst),
        .out_fault_o     (out_fault)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a[7:2] == 6'd2) return 2'd2;
        if (a[7:2] == 6'd9) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the falling edge, then sample and update the models.
    task automatic cycle(input bit redir, input logic [31:0] tgt, input bit ordy);
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = tgt;
        out_ready      = ordy;
        if (ar_deny > 0) begin
            mem_arready = 1'b0;
            ar_deny--;
        end else begin
            mem_arready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (pend && pend_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = inst_of(pend_addr);
            mem_rresp  = resp_of(pend_addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_rresp  = '0;
            if (pend) pend_delay--;
        end
        #1;
        cyc++;
        since_hs++;
        if (redir) check_eq("out_valid_killed", 32'(out_valid), 32'd0);
        if (mem_arvalid && mem_arready) begin
            check_eq("one_outstanding", 32'(pend), 32'd0);
            acc_q.push_back(mem_araddr);
            acc_cyc.push_back(cyc);
            pend       = 1'b1;
            pend_addr  = mem_araddr;
            pend_delay = rand_mem ? int'($urandom_range(0, 3)) : 0;
        end else if (mem_rvalid && mem_rready) begin
            pend = 1'b0;
        end
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            hs_cnt++;
            since_hs = 0;
            check_eq("hs_pc", out_pc, exp_pc);
            check_eq("hs_inst", out_inst, exp_mis ? 32'd0 : inst_of(exp_pc));
            check_eq("hs_fault", 32'(out_fault), exp_mis ? 32'd1 : 32'(resp_of(exp_pc) != 2'd0));
            exp_pc  = exp_pc + 32'd4;
            exp_mis = 1'b0;
        end
        if (redir) begin
            exp_pc  = MisEn ? tgt : {tgt[31:2], 2'b00};
            exp_mis = MisEn && (tgt[1:0] != 2'b00);
        end
    endtask

    task automatic wait_hold(input string tag);
        int n = 0;
        cycle(1'b0, '0, 1'b0);
        while (!out_valid && n < 30) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        check_eq(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_acc(input int cnt, input string tag);
        int n = 0;
        while (acc_q.size() < cnt && n < 40) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        check_eq(tag, 32'(acc_q.size()), 32'(cnt));
    endtask

    initial begin
        logic [31:0] old_addr;
        logic [31:0] tgt;
        int          hs0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_arvalid", 32'(mem_arvalid), 32'd0);
        check_eq("rst_rready", 32'(mem_rready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_araddr", mem_araddr, ResetPc);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_fault", 32'(out_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch, zero-wait memory
        wait_acc(3, "seq_accepts");
        check_eq("seq_addr0", acc_q[0], 32'h8000_0000);
        check_eq("seq_addr1", acc_q[1], 32'h8000_0004);
        check_eq("seq_addr2", acc_q[2], 32'h8000_0008);
        check_eq("seq_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check_eq("seq_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

        // Downstream stall in HOLD; 8000_0008 also returns a fault response
        wait_hold("hold08_reached");
        check_eq("fault_pc", out_pc, 32'h8000_0008);
        check_eq("fault_flag", 32'(out_fault), 32'd1);
        acc_q.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_pc", out_pc, 32'h8000_0008);
            check_eq("stall_inst", out_inst, inst_of(32'h8000_0008));
        end
        check_eq("stall_no_req", 32'(acc_q.size()), 32'd0);
        cycle(1'b0, '0, 1'b1);
        wait_acc(1, "after_stall_acc");
        check_eq("after_stall_addr", acc_q[0], 32'h8000_000C);

        // Redirect while the address phase is stalled
        wait_hold("hold0c_reached");
        ar_deny = 4;
        cycle(1'b0, '0, 1'b1);
        old_addr = exp_pc;
        acc_q.delete();
        ov_cnt = 0;
        cycle(1'b1, 32'h8000_0100, 1'b1);
        check_eq("stallreq_arvalid", 32'(mem_arvalid), 32'd1);
        check_eq("stallreq_addr_a", mem_araddr, old_addr);
        repeat (2) begin
            cycle(1'b0, '0, 1'b1);
            check_eq("stallreq_addr_b", mem_araddr, old_addr);
        end
        wait_acc(2, "redir_accepts");
        check_eq("redir_old_addr", acc_q[0], old_addr);
        check_eq("redir_new_addr", acc_q[1], 32'h8000_0100);
        check_eq("redir_dropped", 32'(ov_cnt), 32'd0);

        // PC wrap
        wait_hold("hold100_reached");
        acc_q.delete();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_acc(2, "wrap_accepts");
        check_eq("wrap_top", acc_q[0], 32'hFFFF_FFFC);
        check_eq("wrap_zero", acc_q[1], 32'h0000_0000);

        // Misaligned redirect, from HOLD and while a request is in flight
        wait_hold("hold0_reached");
        acc_q.delete();
        cycle(1'b1, 32'h8000_0102, 1'b0);
        wait_hold("mis_hold");
        if (MisEn) begin
            check_eq("mis_no_req", 32'(acc_q.size()), 32'd0);
            check_eq("mis_pc", out_pc, 32'h8000_0102);
            check_eq("mis_inst", out_inst, 32'd0);
            check_eq("mis_fault", 32'(out_fault), 32'd1);
        end else begin
            check_eq("mis_req_cnt", 32'(acc_q.size()), 32'd1);
            check_eq("mis_req_addr", acc_q[0], 32'h8000_0100);
            check_eq("mis_pc", out_pc, 32'h8000_0100);
            check_eq("mis_fault", 32'(out_fault), 32'd0);
        end
        acc_q.delete();
        cycle(1'b1, 32'h8000_0200, 1'b1);
        cycle(1'b1, 32'h8000_0302, 1'b0);
        wait_hold("mis2_hold");
        check_eq("mis2_first_req", acc_q[0], 32'h8000_0200);
        check_eq("mis2_pc", out_pc, MisEn ? 32'h8000_0302 : 32'h8000_0300);
        check_eq("mis2_fault", 32'(out_fault), 32'(MisEn));
        check_eq("mis2_req_cnt", 32'(acc_q.size()), MisEn ? 32'd1 : 32'd2);
        cycle(1'b1, 32'h8000_1000, 1'b1);

        // Asynchronous reset in the middle of a transaction
        for (int i = 0; i < 10 && !mem_rready; i++) cycle(1'b0, '0, 1'b1);
        check_eq("pre_rst_wait", 32'(mem_rready), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_arvalid", 32'(mem_arvalid), 32'd0);
        check_eq("mid_rst_rready", 32'(mem_rready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_araddr", mem_araddr, ResetPc);
        pend       = 1'b0;
        mem_rvalid = 1'b0;
        exp_pc     = ResetPc;
        exp_mis    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
        wait_acc(1, "post_rst_acc");
        check_eq("post_rst_addr", acc_q[0], ResetPc);

        // Random traffic
        rand_mem = 1'b1;
        hs0      = hs_cnt;
        since_hs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            if (MisEn) tgt[1:0] = 2'b00;
            cycle($urandom_range(0, 19) == 0, tgt, $urandom_range(0, 3) != 0);
            if (since_hs > 300) begin
                check_eq("progress", 32'(since_hs), 32'd300);
                since_hs = 0;
            end
        end
        check_eq("rand_handshakes", 32'((hs_cnt - hs0) > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
